// File: rtl/dmem_responder_if.sv
// Memory request interface between the load/store unit (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_byteen;
    logic              mem_we;
    logic              mem_req;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    modport master (
        output mem_addr, mem_byteen, mem_we, mem_req, mem_wdata,
        input  mem_rdata, mem_err
    );

    modport slave (
        input  mem_addr, mem_byteen, mem_we, mem_req, mem_wdata,
        output mem_rdata, mem_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-writable word RAM behind the load/store port.
// One access per request, 1-cycle read latency, held status, event counters.
module dmem_responder #(
    parameter int          XLEN        = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   mem,
    input  logic              cnt_clr,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt,
    output logic [31:0]       err_cnt
);
    localparam int              IDX_W = $clog2(DEPTH_WORDS);
    localparam int              LANES = XLEN / 8;
    localparam logic [XLEN-1:0] SPAN  = XLEN'(DEPTH_WORDS * 4);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic              err_q, err_d;
    logic [31:0]       rd_cnt_q, rd_cnt_d;
    logic [31:0]       wr_cnt_q, wr_cnt_d;
    logic [31:0]       err_cnt_q, err_cnt_d;

    logic [XLEN-1:0]   offset;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              aligned;
    logic              be_ok;
    logic              legal;
    logic              accept;
    logic              ram_we;
    logic              rd_load;
    logic [XLEN-1:0]   rdata_w;

    // Address decode: subtracting the base folds "below base" into a huge
    // offset, so a single compare covers both ends of the window.
    always_comb begin
        offset   = mem.mem_addr - BASE_ADDR;
        in_range = (offset < SPAN);
        aligned  = (mem.mem_addr[1:0] == 2'b00);
        idx      = offset[IDX_W+1:2];
        case (mem.mem_byteen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
        legal   = in_range && aligned && be_ok;
        accept  = (state_q == IDLE) && mem.mem_req;
        ram_we  = accept && legal && mem.mem_we;
        rd_load = accept && legal && !mem.mem_we;
    end

    // FSM next state: a request is taken only from IDLE, so a held req
    // never triggers a second access.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem.mem_req)  state_d = ACTIVE;
            ACTIVE:  if (!mem.mem_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status and counter next state; clear beats a coincident acceptance.
    always_comb begin
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            err_d = !legal;
            if (!legal)          err_cnt_d = err_cnt_q + 32'd1;
            else if (mem.mem_we) wr_cnt_d  = wr_cnt_q + 32'd1;
            else                 rd_cnt_d  = rd_cnt_q + 32'd1;
        end
        if (cnt_clr) begin
            rd_cnt_d  = '0;
            wr_cnt_d  = '0;
            err_cnt_d = '0;
        end
    end

    // State, status and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // One RAM column per byte lane so each lane has its own write enable.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] ram_q [DEPTH_WORDS];
            logic [7:0] rd_lane_q;

            // Lane write on the acceptance edge of a legal, enabled write.
            always_ff @(posedge clk) begin
                if (ram_we && mem.mem_byteen[gi])
                    ram_q[idx] <= mem.mem_wdata[8*gi +: 8];
            end

            // Registered read lane: loads on every acceptance (zero unless a
            // legal read) and holds otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rd_lane_q <= 8'h00;
                else if (accept)
                    rd_lane_q <= rd_load ? ram_q[idx] : 8'h00;
            end

            assign rdata_w[8*gi +: 8] = rd_lane_q;
        end
    endgenerate

    assign mem.mem_rdata = rdata_w;
    assign mem.mem_err   = err_q;
    assign rd_cnt        = rd_cnt_q;
    assign wr_cnt        = wr_cnt_q;
    assign err_cnt       = err_cnt_q;
endmodule
